alu8: RTL and testbench



---
 rtl/alu8.sv | 107 ++++++++++
 tb/tb_alu8.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu8 : 8-bit ALU with combinational result/zero and registered Z/C/V/N.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] entrada1,
  input  logic [WIDTH-1:0] entrada2,
  input  logic [2:0]       sinal_ula,
  output logic [WIDTH-1:0] saida_ula,
  output logic             zero,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n
);

  localparam logic [2:0] c_OP_AND  = 3'b000;
  localparam logic [2:0] c_OP_OR   = 3'b001;
  localparam logic [2:0] c_OP_ADD  = 3'b010;
  localparam logic [2:0] c_OP_SUB  = 3'b011;
  localparam logic [2:0] c_OP_SLT  = 3'b100;
  localparam logic [2:0] c_OP_XOR  = 3'b101;
  localparam logic [2:0] c_OP_NOR  = 3'b110;
  localparam logic [2:0] c_OP_SLTU = 3'b111;

  localparam logic [WIDTH-1:0] c_ZERO_W  = '0;
  localparam logic [WIDTH:0]   c_ONE_W1  = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_sltu;
  logic             w_slt;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_ovf;

  logic flag_z_q, flag_c_q, flag_v_q, flag_n_q;
  logic flag_z_d, flag_c_d, flag_v_d, flag_n_d;

  assign w_sum  = {1'b0, entrada1} + {1'b0, entrada2};
  // Bit WIDTH of A + ~B + 1 is the no-borrow indication (A >= B unsigned).
  assign w_diff = {1'b0, entrada1} + {1'b0, ~entrada2} + c_ONE_W1;
  assign w_sltu = ~w_diff[WIDTH];
  // Differing signs decide directly; equal signs reduce to the unsigned compare.
  assign w_slt  = (entrada1[WIDTH-1] != entrada2[WIDTH-1]) ? entrada1[WIDTH-1] : w_sltu;

  always_comb begin
    w_result = c_ZERO_W;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (sinal_ula)
      c_OP_AND:  w_result = entrada1 & entrada2;
      c_OP_OR:   w_result = entrada1 | entrada2;
      c_OP_ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
        w_ovf    = (entrada1[WIDTH-1] == entrada2[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != entrada1[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_result = w_diff[WIDTH-1:0];
        w_carry  = w_diff[WIDTH];
        w_ovf    = (entrada1[WIDTH-1] != entrada2[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != entrada1[WIDTH-1]);
      end
      c_OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
      c_OP_XOR:  w_result = entrada1 ^ entrada2;
      c_OP_NOR:  w_result = ~(entrada1 | entrada2);
      c_OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_sltu};
      default:   w_result = c_ZERO_W;
    endcase
  end

  assign saida_ula = w_result;
  assign zero      = (w_result == c_ZERO_W);

  assign flag_z_d = zero;
  assign flag_c_d = w_carry;
  assign flag_v_d = w_ovf;
  assign flag_n_d = w_result[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;
  assign flag_n = flag_n_q;

endmodule
`default_nettype wire

// File: tb/tb_alu8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu8 : randomized and directed self-checking bench for alu8.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] entrada1;
  logic [7:0] entrada2;
  logic [2:0] sinal_ula;
  logic [7:0] saida_ula;
  logic       zero, flag_z, flag_c, flag_v, flag_n;

  int  checks   = 0;
  int  failures = 0;
  bit  run      = 1'b0;

  logic exp_z = 1'b0, exp_c = 1'b0, exp_v = 1'b0, exp_n = 1'b0;

  alu8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .entrada1  (entrada1),
    .entrada2  (entrada2),
    .sinal_ula (sinal_ula),
    .saida_ula (saida_ula),
    .zero      (zero),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_n    (flag_n)
  );

  always #5 clk = ~clk;

  // Reference computed with plain integer arithmetic; overflow is a range check.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] op, output logic [7:0] r,
                                output logic c, output logic v);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int t;
    c = 1'b0;
    v = 1'b0;
    r = 8'd0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        t = ua + ub;
        r = t[7:0];
        c = (t > 255);
        v = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      3'd3: begin
        t = ua - ub;
        r = t[7:0];
        c = (ua >= ub);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      3'd4: r = (sa < sb) ? 8'd1 : 8'd0;
      3'd5: r = a ^ b;
      3'd6: r = ~(a | b);
      default: r = (ua < ub) ? 8'd1 : 8'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] r;
    logic c, v;
    if (!rst_n) begin
      exp_z = 1'b0; exp_c = 1'b0; exp_v = 1'b0; exp_n = 1'b0;
    end else begin
      model(entrada1, entrada2, sinal_ula, r, c, v);
      exp_z = (r == 8'd0);
      exp_c = c;
      exp_v = v;
      exp_n = r[7];
    end
  end

  always @(negedge clk) begin
    logic [7:0] r;
    logic c, v;
    if (run) begin
      model(entrada1, entrada2, sinal_ula, r, c, v);
      chk("model_result", saida_ula, r);
      chk("model_zero",   zero,   (r == 8'd0));
      chk("model_flag_z", flag_z, exp_z);
      chk("model_flag_c", flag_c, exp_c);
      chk("model_flag_v", flag_v, exp_v);
      chk("model_flag_n", flag_n, exp_n);
    end
  end

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clk);
    #1;
    entrada1  = a;
    entrada2  = b;
    sinal_ula = op;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h7F;
      3: return 8'h80;
      4: return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    entrada1  = 8'd0;
    entrada2  = 8'd0;
    sinal_ula = 3'd0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    chk("reset_flag_z", flag_z, 0);
    chk("reset_flag_c", flag_c, 0);
    chk("reset_flag_v", flag_v, 0);
    chk("reset_flag_n", flag_n, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run = 1'b1;

    apply(8'd6, 8'd3, 3'b000);   chk("and_6_3", saida_ula, 2); chk("and_zero", zero, 0);
    apply(8'd4, 8'd11, 3'b001);  chk("or_4_11", saida_ula, 15);
    apply(8'd6, 8'd31, 3'b010);  chk("add_6_31", saida_ula, 37);
    apply(8'd255, 8'd1, 3'b010); chk("add_255_1", saida_ula, 0); chk("add_255_1_zero", zero, 1);
    after_edge();
    chk("add_255_1_flag_c", flag_c, 1);
    chk("add_255_1_flag_z", flag_z, 1);
    chk("add_255_1_flag_v", flag_v, 0);
    apply(8'd4, 8'd4, 3'b011);   chk("sub_4_4", saida_ula, 0); chk("sub_4_4_zero", zero, 1);
    apply(8'd23, 8'd4, 3'b011);  chk("sub_23_4", saida_ula, 19); chk("sub_23_4_zero", zero, 0);
    apply(8'd0, 8'd1, 3'b011);   chk("sub_0_1", saida_ula, 255);
    after_edge();
    chk("sub_0_1_flag_c", flag_c, 0);
    chk("sub_0_1_flag_n", flag_n, 1);
    apply(8'd127, 8'd1, 3'b010); chk("add_127_1", saida_ula, 128);
    after_edge();
    chk("add_127_1_flag_v", flag_v, 1);
    chk("add_127_1_flag_n", flag_n, 1);
    apply(8'd4, 8'd7, 3'b100);   chk("slt_4_7", saida_ula, 1);
    apply(8'd5, 8'd4, 3'b100);   chk("slt_5_4", saida_ula, 0);
    apply(8'h80, 8'h7F, 3'b100); chk("slt_80_7f", saida_ula, 1);
    apply(8'h80, 8'h7F, 3'b111); chk("sltu_80_7f", saida_ula, 0);

    // Asynchronous reset between edges, with inputs still moving.
    apply(8'd127, 8'd1, 3'b010);
    after_edge();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_flag_z", flag_z, 0);
    chk("async_rst_flag_c", flag_c, 0);
    chk("async_rst_flag_v", flag_v, 0);
    chk("async_rst_flag_n", flag_n, 0);
    entrada1 = 8'hFF; entrada2 = 8'h01; sinal_ula = 3'b010;
    #1;
    chk("rst_result_tracks", saida_ula, 0);
    chk("rst_zero_tracks", zero, 1);
    after_edge();
    chk("rst_hold_flag_c", flag_c, 0);
    chk("rst_hold_flag_z", flag_z, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    after_edge();
    chk("post_rst_flag_c", flag_c, 1);
    chk("post_rst_flag_z", flag_z, 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      entrada1  = pick();
      entrada2  = pick();
      sinal_ula = 3'($urandom_range(0, 7));
    end

    @(negedge clk);
    #1 run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
